// File: rtl/fifo_push_buffer_pkg.sv
// Shared defaults and pointer-width helper for the register-write push FIFO.
package fifo_push_buffer_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;

  // Pointer carries one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_push_buffer_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_push_buffer_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_push_buffer.sv
// First-word fall-through push FIFO with sticky overflow/underflow flags.
// Optional almost_full/almost_empty outputs under FIFO_PUSH_BUFFER_ALMOST_EN.
module fifo_push_buffer
  import fifo_push_buffer_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      wr_valid,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_ready,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  input  logic                      rd_ready,
  output logic [ptr_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      empty,
  output logic                      ovf_sticky,
  output logic                      udf_sticky,
  input  logic                      clr_sticky
`ifdef FIFO_PUSH_BUFFER_ALMOST_EN
  ,
  output logic                      almost_full,
  output logic                      almost_empty
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [DATA_W-1:0] ram_q;
  logic              push, pop, drop, udf_set;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign level    = wr_ptr - rd_ptr;

  // A write while full is still taken when the head is popped on the same edge;
  // only a write that finds no slot is dropped and flagged.
  assign pop     = rd_valid && rd_ready;
  assign push    = wr_valid && (!full || pop);
  assign drop    = wr_valid && full && !pop;
  assign udf_set = rd_ready && !rd_valid;

  assign wr_ptr_nxt = wr_ptr + PW'(push);
  assign rd_ptr_nxt = rd_ptr + PW'(pop);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (drop)            ovf_sticky <= 1'b1;
      else if (clr_sticky) ovf_sticky <= 1'b0;
      if (udf_set)         udf_sticky <= 1'b1;
      else if (clr_sticky) udf_sticky <= 1'b0;
    end
  end

  fifo_push_buffer_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (ACLK),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q)
  );

  // Stale array contents never reach the port while nothing is stored.
  assign rd_data = empty ? '0 : ram_q;

`ifdef FIFO_PUSH_BUFFER_ALMOST_EN
  logic [PW-1:0] level_nxt;
  assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_nxt >= PW'(AF_LEVEL));
      almost_empty <= (level_nxt <= PW'(AE_LEVEL));
    end
  end
`endif

endmodule

// File: doc/fifo_push_buffer.md
FIFO_PUSH_BUFFER -- requirements
Module: fifo_push_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each FIFO word, matching the FIFO_AXI data bus.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries, power of two, range 4..256.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost-full threshold.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost-empty threshold.
REQ-005 SHALL have port ACLK, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port ARESET, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port wr_valid, input, 1: upstream register-write word valid.
REQ-008 SHALL have port wr_data, input, DATA_W: upstream word.
REQ-009 SHALL have port wr_ready, output, 1: high when not full.
REQ-010 SHALL have port rd_valid, output, 1: head word available.
REQ-011 SHALL have port rd_data, output, DATA_W: head word, first-word fall-through.
REQ-012 SHALL have port rd_ready, input, 1: downstream consumer accepts head.
REQ-013 SHALL have port level, output, $clog2(DEPTH)+1: current occupancy.
REQ-014 SHALL have port full and empty, outputs, 1 each: occupancy status.
REQ-015 SHALL have port ovf_sticky and udf_sticky, outputs, 1 each: error flags.
REQ-016 SHALL have port clr_sticky, input, 1: single-cycle pulse clearing both sticky flags.

Function
REQ-017 SHALL push when wr_valid && wr_ready; SHALL pop when rd_valid && rd_ready.
REQ-018 SHALL present a word written into an empty FIFO on rd_data/rd_valid one cycle after the push edge.
REQ-019 SHALL keep rd_data stable while rd_valid=1 and rd_ready=0.
REQ-020 SHALL, on simultaneous push and pop when not empty, perform both with level unchanged.
REQ-021 SHALL, on simultaneous push and pop when empty, accept the push only; the pop is not counted.
REQ-022 SHALL, on simultaneous push and pop when full, perform both (wr_ready reflects pre-edge state; pop frees the slot).
REQ-023 SHALL wrap read and write pointers modulo DEPTH, using one extra pointer bit to distinguish full from empty.
REQ-024 SHALL set ovf_sticky when wr_valid=1 while full=1, and drop that word.
REQ-025 SHALL set udf_sticky when rd_ready=1 while rd_valid=0.
REQ-026 SHALL give set priority over clr_sticky when both occur in the same cycle.
REQ-027 SHALL derive full, empty, wr_ready and rd_valid from registered pointers only; no combinational input-to-output paths.

Reset
REQ-028 SHALL, on ARESET high, immediately clear pointers, level=0, empty=1, full=0, wr_ready=1, rd_valid=0, rd_data=0, ovf_sticky=0, udf_sticky=0.
REQ-029 SHALL, on reset mid-operation, discard all stored words, with no output glitch beyond the reset values.
REQ-030 SHALL accept a push on the first rising edge after ARESET deasserts.

Configuration
REQ-031 SHALL, with macro FIFO_PUSH_BUFFER_ALMOST_EN defined, add outputs almost_full (level >= AF_LEVEL) and almost_empty (level <= AE_LEVEL), both registered and reset to 0 and 1 respectively.
REQ-032 SHALL, without FIFO_PUSH_BUFFER_ALMOST_EN, omit those ports and their logic entirely.

Structure
REQ-033 SHALL place the DATA_W/DEPTH defaults and the pointer-width function in shared package fifo_push_buffer_pkg.
REQ-034 SHALL implement storage in sub-module fifo_push_buffer_ram: a simple dual-port array with synchronous write and asynchronous read, and no reset on the array.

Verification
REQ-035 SHALL cover: push 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011, then pop 4 -> data in the same order, level 4->0, empty=1.
REQ-036 SHALL cover: DEPTH=16 with 17 pushes and no pops -> full=1 after the 16th, 17th word dropped, ovf_sticky=1; then clr_sticky -> ovf_sticky=0.
REQ-037 SHALL cover: pop on empty -> udf_sticky=1, level stays 0, rd_valid=0.
REQ-038 SHALL cover: level 8 with simultaneous push/pop for 20 cycles -> level stays 8, pointers wrap, order preserved.
REQ-039 SHALL cover: ARESET asserted at level 5 -> level=0, empty=1 asynchronously; the next push 0x12345678 is read back correctly.
REQ-040 SHALL cover: FIFO_PUSH_BUFFER_ALMOST_EN defined, DEPTH=16 -> almost_full=1 at level 14, almost_empty=1 at level <= 2.
